// File: rtl/icache_refill_sequencer_pkg.sv
// Shared fetch-unit types: I-cache line geometry and the refill sequencer state encoding.
package FetchUnitTypes;

  localparam int ICACHE_LINE_WORDS        = 4;
  localparam int ICACHE_WORD_BITS         = 32;
  localparam int ICACHE_WORD_IDX_WIDTH    = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_LINE_OFFSET_WIDTH = $clog2(ICACHE_LINE_WORDS * ICACHE_WORD_BITS / 8);

  typedef logic [ICACHE_WORD_IDX_WIDTH-1:0] ICacheWordIndexPath;

  typedef enum logic [1:0] {
    IRS_IDLE,
    IRS_REQ,
    IRS_FILL,
    IRS_DONE
  } ICacheRefillState;

endpackage

// File: rtl/icache_refill_sequencer.sv
// I-cache refill sequencer: one line-aligned memory read per miss, streams the returned
// words into the data array, then pulses fillDone so fetch can replay the missed PC.
module icache_refill_sequencer
  import FetchUnitTypes::*;
#(
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          missValid,
  input  logic [ADDR_WIDTH-1:0]         missAddr,
  input  logic                          flush,
  output logic                          memReqValid,
  input  logic                          memReqReady,
  output logic [ADDR_WIDTH-1:0]         memReqAddr,
  input  logic                          memRspValid,
  input  logic [DATA_WIDTH-1:0]         memRspData,
  output logic                          fillWE,
  output logic [ADDR_WIDTH-1:0]         fillAddr,
  output logic [$clog2(LINE_WORDS)-1:0] fillWordIdx,
  output logic [DATA_WIDTH-1:0]         fillData,
  output logic                          fillTagWE,
  output logic                          fillDone,
  output logic                          busy
);

  localparam int IDX_WIDTH = $clog2(LINE_WORDS);
  localparam int OFF_WIDTH = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_WIDTH) - ADDR_WIDTH'(1));
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LINE_WORDS - 1);

  ICacheRefillState       state, nextState;
  logic [IDX_WIDTH-1:0]   wordCnt;
  logic [ADDR_WIDTH-1:0]  lineAddr;
  logic                   abortFlag;
  logic                   acceptMiss;
  logic                   lastBeat;

  assign acceptMiss = (state == IRS_IDLE) && missValid && !flush;
  assign lastBeat   = (state == IRS_FILL) && memRspValid && (wordCnt == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IRS_IDLE;
      wordCnt   <= '0;
      lineAddr  <= '0;
      abortFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (acceptMiss)
        lineAddr <= missAddr & LINE_MASK;
      if (state == IRS_REQ)
        wordCnt <= '0;
      else if (state == IRS_FILL && memRspValid)
        wordCnt <= wordCnt + IDX_WIDTH'(1);
      // Outstanding data cannot be cancelled, so a flush mid-fill only suppresses fillDone.
      if (state == IRS_FILL && flush)
        abortFlag <= 1'b1;
      else if (state == IRS_DONE)
        abortFlag <= 1'b0;
    end
  end

  // NOTE: every output and nextState gets a default first so no path infers a latch.
  always_comb begin
    nextState   = state;
    memReqValid = 1'b0;
    memReqAddr  = '0;
    fillWE      = 1'b0;
    fillAddr    = '0;
    fillWordIdx = '0;
    fillData    = '0;
    fillTagWE   = 1'b0;
    fillDone    = 1'b0;
    busy        = (state != IRS_IDLE);

    unique case (state)
      IRS_IDLE: begin
        if (acceptMiss)
          nextState = IRS_REQ;
      end
      IRS_REQ: begin
        memReqValid = 1'b1;
        memReqAddr  = lineAddr;
        // Acceptance wins over a same-cycle flush: the request is already gone.
        if (memReqReady)
          nextState = IRS_FILL;
        else if (flush)
          nextState = IRS_IDLE;
      end
      IRS_FILL: begin
        if (memRspValid) begin
          fillWE      = 1'b1;
          fillAddr    = lineAddr;
          fillWordIdx = wordCnt;
          fillData    = memRspData;
          fillTagWE   = lastBeat;
          if (lastBeat)
            nextState = IRS_DONE;
        end
      end
      IRS_DONE: begin
        fillDone  = !abortFlag && !flush;
        nextState = IRS_IDLE;
      end
      default: nextState = IRS_IDLE;
    endcase
  end

endmodule
